parallel_bus_master: RTL and testbench

- Next-generation parallel-bus master for DDS/synth register access.
- Queues bus commands in a small FIFO and executes them back-to-back on an asynchronous-style parallel bus (addr, data, active-low wr/rd strobes).
- Setup, strobe and hold phases are individually timed; read data is returned with a valid pulse.
- Sits between the control/command decoder and the device pins; replaces single-shot load/busy handshaking with valid/ready streaming.

---
 rtl/parallel_bus_master.sv | 213 +++++++++++++++++++++
 tb/tb_parallel_bus_master.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_bus_master.sv
// Parallel-bus master: queues register-access commands and replays them on an
// addr/data bus with active-low wr/rd strobes and individually timed phases.
module parallel_bus_master #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETUP_CYC     = 1,
    parameter int RD_STROBE_CYC = 2,
    parameter int WR_STROBE_CYC = 2,
    parameter int HOLD_CYC      = 1,
    parameter bit BUS_16BIT     = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_rw,
    input  logic [ADDR_WIDTH-1:0]       cmd_addr,
    input  logic [DATA_WIDTH-1:0]       cmd_wdata,
    output logic                        rd_valid,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic                        done,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        pwd,
    output logic                        wr,
    output logic                        rd,
    output logic [ADDR_WIDTH-1:0]       p_addr,
    output logic [DATA_WIDTH-1:0]       p_wdata,
    input  logic [DATA_WIDTH-1:0]       p_rdata,
    output logic                        data_tri_select
);
    // A zero phase length still has to occupy one cycle on the bus.
    localparam int SETUP_EFF = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
    localparam int RD_EFF    = (RD_STROBE_CYC < 1) ? 1 : RD_STROBE_CYC;
    localparam int WR_EFF    = (WR_STROBE_CYC < 1) ? 1 : WR_STROBE_CYC;
    localparam int HOLD_EFF  = (HOLD_CYC < 1) ? 1 : HOLD_CYC;
    localparam int MAX_A     = (SETUP_EFF > HOLD_EFF) ? SETUP_EFF : HOLD_EFF;
    localparam int MAX_B     = (RD_EFF > WR_EFF) ? RD_EFF : WR_EFF;
    localparam int MAX_CYC   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W     = $clog2(MAX_CYC + 1);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int LVL_W     = PTR_W + 1;
    localparam int ENT_W     = 1 + ADDR_WIDTH + DATA_WIDTH;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_EFF);
    localparam logic [CNT_W-1:0] RD_LD    = CNT_W'(RD_EFF);
    localparam logic [CNT_W-1:0] WR_LD    = CNT_W'(WR_EFF);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_EFF);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    logic [ENT_W-1:0]      fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [LVL_W-1:0]      level_r;
    logic [LVL_W-1:0]      level_n_s;
    logic                  cmd_ready_r;
    logic                  busy_r;
    logic                  push_s;
    logic                  pop_s;
    logic                  last_s;
    logic [ENT_W-1:0]      head_s;

    logic [1:0]            state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  rw_r;
    logic                  wr_r;
    logic                  rd_r;
    logic                  dts_r;
    logic [ADDR_WIDTH-1:0] p_addr_r;
    logic [DATA_WIDTH-1:0] p_wdata_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  rd_valid_r;
    logic                  done_r;

    assign head_s = fifo_mem_r[rd_ptr_r];
    assign last_s = (cnt_r == CNT_ONE);

    // Queue handshake and next occupancy
    always_comb begin
        push_s    = cmd_valid & cmd_ready_r;
        pop_s     = (state_r == ST_IDLE) && (level_r != {LVL_W{1'b0}});
        level_n_s = level_r;
        if (push_s && !pop_s) begin
            level_n_s = level_r + LVL_W'(1);
        end else if (!push_s && pop_s) begin
            level_n_s = level_r - LVL_W'(1);
        end else begin
            level_n_s = level_r;
        end
    end

    // Command storage array (contents need no reset, occupancy is tracked separately)
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {cmd_rw, cmd_addr, cmd_wdata};
        end
    end

    // Queue pointers, occupancy and the flags derived from it
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            level_r     <= {LVL_W{1'b0}};
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r     <= level_n_s;
            cmd_ready_r <= (level_n_s != LVL_W'(FIFO_DEPTH));
            // Non-IDLE state includes HOLD's final cycle, so busy covers the done pulse.
            busy_r      <= (state_r != ST_IDLE) || pop_s || (level_n_s != {LVL_W{1'b0}});
        end
    end

    // Bus sequencer: one down-counter, reloaded on every state entry, times each phase
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            rw_r       <= 1'b0;
            wr_r       <= 1'b1;
            rd_r       <= 1'b1;
            dts_r      <= 1'b1;
            p_addr_r   <= {ADDR_WIDTH{1'b0}};
            p_wdata_r  <= {DATA_WIDTH{1'b0}};
            rdata_r    <= {DATA_WIDTH{1'b0}};
            rd_valid_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            rd_valid_r <= 1'b0;
            done_r     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        {rw_r, p_addr_r, p_wdata_r} <= head_s;
                        dts_r   <= head_s[ENT_W-1];
                        cnt_r   <= SETUP_LD;
                        state_r <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (last_s) begin
                        if (rw_r) begin
                            rd_r  <= 1'b0;
                            cnt_r <= RD_LD;
                        end else begin
                            wr_r  <= 1'b0;
                            cnt_r <= WR_LD;
                        end
                        state_r <= ST_STROBE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_STROBE: begin
                    if (last_s) begin
                        wr_r <= 1'b1;
                        rd_r <= 1'b1;
                        if (rw_r) begin
                            rdata_r    <= p_rdata;
                            rd_valid_r <= 1'b1;
                        end
                        cnt_r   <= HOLD_LD;
                        state_r <= ST_HOLD;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (last_s) begin
                        done_r  <= 1'b1;
                        dts_r   <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    wr_r    <= 1'b1;
                    rd_r    <= 1'b1;
                    dts_r   <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready       = cmd_ready_r;
    assign busy            = busy_r;
    assign fifo_level      = level_r;
    assign rd_valid        = rd_valid_r;
    assign rdata           = rdata_r;
    assign done            = done_r;
    assign pwd             = BUS_16BIT;
    assign wr              = wr_r;
    assign rd              = rd_r;
    assign p_addr          = p_addr_r;
    assign p_wdata         = p_wdata_r;
    assign data_tri_select = dts_r;

endmodule

// File: tb/tb_parallel_bus_master.sv
// Bench for parallel_bus_master: a default-timing instance (u0) and a slow-timing
// instance (u1), each checked every cycle against a per-transaction timeline model.
`timescale 1ns/1ps
module tb_parallel_bus_master;
    localparam int DEPTH = 4;
    localparam int PA_SETUP = 1, PA_RD = 2, PA_WR = 2, PA_HOLD = 1;
    localparam int PB_SETUP = 3, PB_RD = 2, PB_WR = 0, PB_HOLD = 4;

    typedef struct packed {
        logic        rw;
        logic [7:0]  addr;
        logic [15:0] data;
    } cmd_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      p_rdata;
    logic [1:0]       cmd_valid_v, cmd_rw_v;
    logic [1:0][7:0]  cmd_addr_v;
    logic [1:0][15:0] cmd_wdata_v;
    logic [1:0]       cmd_ready_v, rd_valid_v, done_v, busy_v, pwd_v, wr_v, rd_v, dts_v;
    logic [1:0][2:0]  lvl_v;
    logic [1:0][7:0]  paddr_v;
    logic [1:0][15:0] pwdata_v, rdata_v;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int done_cnt0 = 0;
    int rdv_cnt0 = 0;
    int done_t0[$];

    cmd_t        mq0[$], mq1[$];
    bit          m_act[2];
    int          m_k[2];
    cmd_t        m_cur[2];
    logic [7:0]  m_paddr[2];
    logic [15:0] m_pwdata[2];
    logic [15:0] m_rdata[2];

    always #5 clk = ~clk;

    parallel_bus_master #(.SETUP_CYC(PA_SETUP), .RD_STROBE_CYC(PA_RD), .WR_STROBE_CYC(PA_WR),
                          .HOLD_CYC(PA_HOLD), .BUS_16BIT(1'b1)) u0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_v[0]), .cmd_ready(cmd_ready_v[0]),
        .cmd_rw(cmd_rw_v[0]), .cmd_addr(cmd_addr_v[0]), .cmd_wdata(cmd_wdata_v[0]),
        .rd_valid(rd_valid_v[0]), .rdata(rdata_v[0]), .done(done_v[0]), .busy(busy_v[0]),
        .fifo_level(lvl_v[0]), .pwd(pwd_v[0]), .wr(wr_v[0]), .rd(rd_v[0]), .p_addr(paddr_v[0]),
        .p_wdata(pwdata_v[0]), .p_rdata(p_rdata), .data_tri_select(dts_v[0]));

    parallel_bus_master #(.SETUP_CYC(PB_SETUP), .RD_STROBE_CYC(PB_RD), .WR_STROBE_CYC(PB_WR),
                          .HOLD_CYC(PB_HOLD), .BUS_16BIT(1'b0)) u1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_v[1]), .cmd_ready(cmd_ready_v[1]),
        .cmd_rw(cmd_rw_v[1]), .cmd_addr(cmd_addr_v[1]), .cmd_wdata(cmd_wdata_v[1]),
        .rd_valid(rd_valid_v[1]), .rdata(rdata_v[1]), .done(done_v[1]), .busy(busy_v[1]),
        .fifo_level(lvl_v[1]), .pwd(pwd_v[1]), .wr(wr_v[1]), .rd(rd_v[1]), .p_addr(paddr_v[1]),
        .p_wdata(pwdata_v[1]), .p_rdata(p_rdata), .data_tri_select(dts_v[1]));

    function automatic int eff(int x);
        return (x < 1) ? 1 : x;
    endfunction

    function automatic int s_of(int i);
        return (i == 0) ? eff(PA_SETUP) : eff(PB_SETUP);
    endfunction

    function automatic int h_of(int i);
        return (i == 0) ? eff(PA_HOLD) : eff(PB_HOLD);
    endfunction

    function automatic int stb_of(int i, bit rw);
        if (i == 0) return rw ? eff(PA_RD) : eff(PA_WR);
        else        return rw ? eff(PB_RD) : eff(PB_WR);
    endfunction

    // Cycles from pop to the done cycle for the transaction in flight
    function automatic int t_of(int i);
        return s_of(i) + stb_of(i, m_cur[i].rw) + h_of(i);
    endfunction

    function automatic int qsize(int i);
        if (i == 0) return mq0.size();
        else        return mq1.size();
    endfunction

    function automatic cmd_t qpop(int i);
        if (i == 0) return mq0.pop_front();
        else        return mq1.pop_front();
    endfunction

    function automatic void qpush(int i, cmd_t c);
        if (i == 0) mq0.push_back(c);
        else        mq1.push_back(c);
    endfunction

    function automatic void qclear(int i);
        if (i == 0) mq0.delete();
        else        mq1.delete();
    endfunction

    function automatic bit e_strobe(int i, bit rw_sel);
        return m_act[i] && (m_cur[i].rw == rw_sel) && (m_k[i] >= s_of(i)) &&
               (m_k[i] < s_of(i) + stb_of(i, rw_sel));
    endfunction

    task automatic check(input int i, input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL u%0d.%s actual=%0h required=%0h cyc=%0d", i, nm, act, req, cyc);
        end
    endtask

    task automatic model_step(input int i);
        int   sz;
        bit   idle;
        cmd_t c;
        if (!rst) begin
            m_act[i] = 1'b0; m_k[i] = 0; m_cur[i] = '0;
            m_paddr[i] = 8'h00; m_pwdata[i] = 16'h0000; m_rdata[i] = 16'h0000;
            qclear(i);
        end else begin
            sz   = qsize(i);
            idle = !m_act[i] || (m_k[i] == t_of(i));
            if (!idle) begin
                m_k[i]++;
                if (m_cur[i].rw && (m_k[i] == s_of(i) + stb_of(i, 1'b1))) m_rdata[i] = p_rdata;
            end else if (sz > 0) begin
                c = qpop(i);
                m_cur[i] = c; m_act[i] = 1'b1; m_k[i] = 0;
                m_paddr[i] = c.addr; m_pwdata[i] = c.data;
            end else begin
                m_act[i] = 1'b0;
            end
            if (cmd_valid_v[i] && (sz < DEPTH)) begin
                c.rw = cmd_rw_v[i]; c.addr = cmd_addr_v[i]; c.data = cmd_wdata_v[i];
                qpush(i, c);
            end
        end
    endtask

    // Reference model advance on each active edge
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
        if (!rst) chk_en = 1'b1;
        cyc++;
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check(i, "wr", wr_v[i], !e_strobe(i, 1'b0));
                check(i, "rd", rd_v[i], !e_strobe(i, 1'b1));
                check(i, "dts", dts_v[i], (m_act[i] && m_k[i] < t_of(i)) ? m_cur[i].rw : 1'b1);
                check(i, "p_addr", paddr_v[i], m_paddr[i]);
                check(i, "p_wdata", pwdata_v[i], m_pwdata[i]);
                check(i, "rd_valid", rd_valid_v[i],
                      m_act[i] && m_cur[i].rw && (m_k[i] == s_of(i) + stb_of(i, 1'b1)));
                check(i, "rdata", rdata_v[i], m_rdata[i]);
                check(i, "done", done_v[i], m_act[i] && (m_k[i] == t_of(i)));
                check(i, "busy", busy_v[i], m_act[i] || (qsize(i) > 0));
                check(i, "fifo_level", lvl_v[i], qsize(i));
                check(i, "cmd_ready", cmd_ready_v[i], qsize(i) != DEPTH);
                check(i, "pwd", pwd_v[i], (i == 0) ? 1'b1 : 1'b0);
            end
            if (done_v[0]) begin
                done_cnt0++;
                done_t0.push_back(cyc);
            end
            if (rd_valid_v[0]) rdv_cnt0++;
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic push(input int i, input bit rw, input logic [7:0] a, input logic [15:0] d);
        bit acc = 1'b0;
        cmd_valid_v[i] = 1'b1; cmd_rw_v[i] = rw; cmd_addr_v[i] = a; cmd_wdata_v[i] = d;
        for (int n = 0; n < 100 && !acc; n++) begin
            acc = cmd_ready_v[i];
            @(negedge clk);
        end
        cmd_valid_v[i] = 1'b0;
        check(i, "push_accepted", acc, 1'b1);
    endtask

    task automatic wait_idle;
        bit idle = 1'b0;
        for (int n = 0; n < 200 && !idle; n++) begin
            tick();
            idle = !m_act[0] && !m_act[1] && (mq0.size() == 0) && (mq1.size() == 0);
        end
        check(0, "drain", idle, 1'b1);
    endtask

    initial begin
        int d0, r0, t0, n_setup, n_low, n_hold, n_rd;
        bit seen;
        rst = 1'b0; p_rdata = 16'h0000;
        cmd_valid_v = 2'b11; cmd_rw_v = 2'b00;
        cmd_addr_v = '{8'hAA, 8'h55}; cmd_wdata_v = '{16'hFFFF, 16'h1111};

        // Reset held with commands offered: nothing may be accepted
        repeat (3) begin
            tick();
            check(0, "rst_wr", wr_v[0], 1'b1);
            check(0, "rst_rd", rd_v[0], 1'b1);
            check(0, "rst_dts", dts_v[0], 1'b1);
            check(0, "rst_ready", cmd_ready_v[0], 1'b1);
            check(0, "rst_level", lvl_v[0], 3'd0);
        end
        cmd_valid_v = 2'b00;
        rst = 1'b1;
        tick();
        check(0, "post_rst_level", lvl_v[0], 3'd0);
        check(1, "post_rst_level", lvl_v[1], 3'd0);

        // Single write: strobe low E2..E4, done at E5
        push(0, 1'b0, 8'h12, 16'hBEEF);
        check(0, "w_level_E0", lvl_v[0], 3'd1);
        tick();
        check(0, "w_addr_E1", paddr_v[0], 8'h12);
        check(0, "w_data_E1", pwdata_v[0], 16'hBEEF);
        check(0, "w_dts_E1", dts_v[0], 1'b0);
        check(0, "w_wr_E1", wr_v[0], 1'b1);
        tick(); check(0, "w_wr_E2", wr_v[0], 1'b0);
        tick(); check(0, "w_wr_E3", wr_v[0], 1'b0);
        tick(); check(0, "w_wr_E4", wr_v[0], 1'b1);
        check(0, "w_done_E4", done_v[0], 1'b0);
        tick(); check(0, "w_done_E5", done_v[0], 1'b1);
        check(0, "w_busy_E5", busy_v[0], 1'b1);
        tick(); check(0, "w_done_E6", done_v[0], 1'b0);
        check(0, "w_busy_E6", busy_v[0], 1'b0);

        // Single read: captured data returned with rd_valid at E4, then held
        p_rdata = 16'h5A5A;
        push(0, 1'b1, 8'h34, 16'h0000);
        tick(); check(0, "r_dts_E1", dts_v[0], 1'b1);
        check(0, "r_addr_E1", paddr_v[0], 8'h34);
        tick(); check(0, "r_rd_E2", rd_v[0], 1'b0);
        tick(); check(0, "r_rd_E3", rd_v[0], 1'b0);
        tick(); check(0, "r_rd_E4", rd_v[0], 1'b1);
        check(0, "r_valid_E4", rd_valid_v[0], 1'b1);
        check(0, "r_rdata_E4", rdata_v[0], 16'h5A5A);
        p_rdata = 16'h1111;
        tick(); check(0, "r_done_E5", done_v[0], 1'b1);
        check(0, "r_valid_E5", rd_valid_v[0], 1'b0);
        check(0, "r_rdata_held", rdata_v[0], 16'h5A5A);
        wait_idle();

        // Burst of five: queue fills to depth, then drains with a 5-cycle period
        p_rdata = 16'hC3C3;
        d0 = done_cnt0; r0 = rdv_cnt0; t0 = done_t0.size();
        push(0, 1'b0, 8'h01, 16'h1001);
        push(0, 1'b1, 8'h02, 16'h2002);
        push(0, 1'b0, 8'h03, 16'h3003);
        push(0, 1'b1, 8'h04, 16'h4004);
        push(0, 1'b0, 8'h05, 16'h5005);
        check(0, "burst_level_full", lvl_v[0], 3'd4);
        check(0, "burst_ready_low", cmd_ready_v[0], 1'b0);
        wait_idle();
        check(0, "burst_done_count", done_cnt0 - d0, 5);
        check(0, "burst_rdvalid_count", rdv_cnt0 - r0, 2);
        for (int k = t0 + 1; k < done_t0.size(); k++)
            check(0, "burst_period", done_t0[k] - done_t0[k-1], 5);

        // Reset during a read strobe with two commands still queued
        p_rdata = 16'h7E7E;
        push(0, 1'b1, 8'h40, 16'h0000);
        push(0, 1'b0, 8'h41, 16'h4141);
        push(0, 1'b0, 8'h42, 16'h4242);
        check(0, "mid_rd_low", rd_v[0], 1'b0);
        check(0, "mid_level", lvl_v[0], 3'd2);
        d0 = done_cnt0; r0 = rdv_cnt0;
        rst = 1'b0;
        tick();
        check(0, "abort_rd", rd_v[0], 1'b1);
        check(0, "abort_wr", wr_v[0], 1'b1);
        check(0, "abort_level", lvl_v[0], 3'd0);
        check(0, "abort_busy", busy_v[0], 1'b0);
        check(0, "abort_dts", dts_v[0], 1'b1);
        rst = 1'b1;
        repeat (8) tick();
        check(0, "abort_no_done", done_cnt0 - d0, 0);
        check(0, "abort_no_rdvalid", rdv_cnt0 - r0, 0);
        check(0, "abort_idle", busy_v[0], 1'b0);

        // Slow instance: 3 setup, 1 write-strobe (zero rounded up), 4 hold cycles
        push(1, 1'b0, 8'h77, 16'h1234);
        n_setup = 0; n_low = 0; n_hold = 0; seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (wr_v[1] == 1'b0) begin
                n_low++;
                seen = 1'b1;
            end else if (dts_v[1] == 1'b0) begin
                if (seen) n_hold++;
                else      n_setup++;
            end
        end
        check(1, "sweep_setup_cycles", n_setup, 3);
        check(1, "sweep_wr_low_cycles", n_low, 1);
        check(1, "sweep_hold_cycles", n_hold, 4);

        p_rdata = 16'h2468;
        push(1, 1'b1, 8'h78, 16'h0000);
        n_rd = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (rd_v[1] == 1'b0) n_rd++;
        end
        check(1, "sweep_rd_low_cycles", n_rd, 2);
        check(1, "sweep_rdata", rdata_v[1], 16'h2468);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1);
    end

endmodule
